// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the HI/LO multiply/divide sequencer:
//               operand width, R-type funct codes, FSM state encoding and an
//               operand-magnitude helper.
// Config      : MULDIV_DIV_EN (consumed by the sequencer and step unit)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Absolute value for signed ops; pass-through for unsigned ops.
  // -2^31 maps to 0x8000_0000, which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Pipeline <-> multiply/divide sequencer bundle.
//               master : EX stage (drives start/funct/rs_val/rt_val/flush)
//               slave  : sequencer (drives stall/busy/done/div_by_zero/hi/lo)
// Config      : MULDIV_DIV_EN (no effect on the bundle itself)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic            start;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, funct, rs_val, rt_val, flush,
    input  stall, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val, flush,
    output stall, busy, done, div_by_zero, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the sequencer datapath.
//               op_div=0 : shift-add multiply step on {hi_acc, multiplier}
//               op_div=1 : restoring-divide step on {remainder, dividend}
// Ports       : op_div   - selects divide step
//               acc      - 64-bit working register
//               opnd     - multiplicand or divisor magnitude
//               acc_next - working register after this iteration
// Config      : MULDIV_DIV_EN - when undefined the divide step is not built
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
(
  input  wire logic              op_div,
  input  wire logic [2*XLEN-1:0] acc,
  input  wire logic [XLEN-1:0]   opnd,
  output logic      [2*XLEN-1:0] acc_next
);

  // Multiply: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole 65-bit result right.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;

  always_comb begin
    w_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    w_mul_next = {w_sum, acc[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Divide: shift left, then trial-subtract the divisor from the 33-bit
  // partial remainder (the bit shifted out of acc[63] must be kept).
  logic [XLEN:0]     w_top;
  logic              w_ge;
  logic [XLEN:0]     w_diff;
  logic [XLEN:0]     w_rem;
  logic [2*XLEN-1:0] w_div_next;
  logic              w_unused_rem_msb;

  always_comb begin
    w_top      = acc[2*XLEN-1:XLEN-1];
    w_ge       = (w_top >= {1'b0, opnd});
    w_diff     = w_top - {1'b0, opnd};
    w_rem      = w_ge ? w_diff : w_top;
    w_div_next = {w_rem[XLEN-1:0], acc[XLEN-2:0], w_ge};
  end

  // The new remainder is always below the divisor, so its MSB is zero.
  assign w_unused_rem_msb = w_rem[XLEN];

  assign acc_next = op_div ? w_div_next : w_mul_next;
`else
  assign acc_next = op_div ? acc : w_mul_next;
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//               32 iterations in RUN, sign correction and HI/LO write in FIX.
//               Stalls the pipeline on any HI/LO op while busy.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - muldiv_sequencer_if.slave (request, stall, results)
// Config      : MULDIV_DIV_EN - enables DIV/DIVU and div_by_zero
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         reset,
  muldiv_sequencer_if.slave bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [4:0]        r_cnt;
  logic              r_is_div;
  logic              r_neg_lo;   // negate product (mul) or quotient (div)
  logic              r_neg_hi;   // negate remainder (div only)
  logic              r_done;

  logic              w_mul_op;
  logic              w_div_op;
  logic              w_hilo_op;
  logic              w_signed;
  logic              w_busy;
  logic              w_stall;
  logic              w_accept;
  logic              w_start_seq;
  logic              w_zero_div;
  logic              w_fix_write;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_hi_fix;
  logic [XLEN-1:0]   w_lo_fix;

  muldiv_step u_step (
    .op_div   (r_is_div),
    .acc      (r_acc),
    .opnd     (r_opnd),
    .acc_next (w_acc_next)
  );

  assign w_busy = (r_state != ST_IDLE);

  // Decode, acceptance and next-state.
  always_comb begin
    w_mul_op     = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
    w_div_op     = 1'b0;
`ifdef MULDIV_DIV_EN
    w_div_op     = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
`endif
    w_hilo_op    = w_mul_op || w_div_op ||
                   (bus.funct == FUNCT_MFHI) || (bus.funct == FUNCT_MTHI) ||
                   (bus.funct == FUNCT_MFLO) || (bus.funct == FUNCT_MTLO);
    w_signed     = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    w_stall      = w_busy && bus.start && w_hilo_op;
    w_accept     = bus.start && w_hilo_op && !w_stall && !bus.flush;
    w_start_seq  = w_accept && (w_mul_op || w_div_op);
    w_zero_div   = w_div_op && (bus.rt_val == '0);
    w_fix_write  = 1'b0;
    w_state_next = r_state;

    case (r_state)
      ST_IDLE: begin
        if (w_start_seq) w_state_next = w_zero_div ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush)           w_state_next = ST_IDLE;
        else if (r_cnt == 5'd0)  w_state_next = ST_FIX;
      end
      ST_FIX: begin
        w_fix_write  = !bus.flush;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_lo ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem  = r_neg_hi ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    if (r_is_div) begin
      w_hi_fix = w_rem;
      w_lo_fix = w_quo;
    end else begin
      w_hi_fix = w_prod[2*XLEN-1:XLEN];
      w_lo_fix = w_prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && bus.funct == FUNCT_MTHI) r_hi <= bus.rs_val;
          if (w_accept && bus.funct == FUNCT_MTLO) r_lo <= bus.rs_val;
          if (w_start_seq) begin
            r_is_div <= w_div_op;
            r_cnt    <= 5'd31;
            r_neg_lo <= w_signed && (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
            r_neg_hi <= w_signed && w_div_op && bus.rs_val[XLEN-1];
            if (w_mul_op) begin
              // Multiplier sits in the low half and is consumed LSB first.
              r_acc  <= {{XLEN{1'b0}}, magnitude(bus.rt_val, w_signed)};
              r_opnd <= magnitude(bus.rs_val, w_signed);
            end else if (w_zero_div) begin
              // Preload the architected divide-by-zero result; FIX copies it.
              r_acc    <= {bus.rs_val, {XLEN{1'b1}}};
              r_opnd   <= '0;
              r_neg_lo <= 1'b0;
              r_neg_hi <= 1'b0;
            end else begin
              r_acc  <= {{XLEN{1'b0}}, magnitude(bus.rs_val, w_signed)};
              r_opnd <= magnitude(bus.rt_val, w_signed);
            end
          end
        end
        ST_RUN: begin
          if (!bus.flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 5'd1;
          end
        end
        ST_FIX: begin
          if (w_fix_write) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV_EN
  logic r_dbz_pend;
  logic r_dbz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dbz_pend <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      if (w_accept)    r_dbz <= 1'b0;
      if (w_start_seq) r_dbz_pend <= w_zero_div;
      if (w_fix_write) r_dbz <= r_dbz_pend;
    end
  end

  assign bus.div_by_zero = r_dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.stall = w_stall;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
//               Divide vectors are exercised when MULDIV_DIV_EN is defined;
//               otherwise DIV/DIVU are checked to be ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge (E0), returning #1 after it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // Count edges until done is seen; -1 when the bound expires.
  task automatic wait_done(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) edges = -1;
  endtask

  // Run n cycles and report whether done ever pulsed.
  task automatic watch_no_done(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    int e;
    int stalls;
    bit seen;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct  = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi",   bus.hi, 0);
    check("rst_lo",   bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz",  bus.div_by_zero, 0);
    reset = 1'b0;

    // MTHI / MTLO in IDLE
    issue(FUNCT_MTHI, 32'h0000_1234, 32'h0);
    check("mthi_hi",   bus.hi, 32'h0000_1234);
    check("mthi_busy", bus.busy, 0);
    issue(FUNCT_MTLO, 32'h0000_5678, 32'h0);
    check("mtlo_lo", bus.lo, 32'h0000_5678);

    // flush together with start: nothing accepted
    bus.flush = 1'b1;
    issue(FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0);
    bus.flush = 1'b0;
    check("flush_start_hi", bus.hi, 32'h0000_1234);

    // Reset in the middle of RUN
    issue(FUNCT_MULT, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    check("midrun_busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("midrun_rst_hi",   bus.hi, 0);
    check("midrun_rst_lo",   bus.lo, 0);
    check("midrun_rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    watch_no_done(40, seen);
    check("midrun_no_done", seen, 0);

    // MULT -3 * 7
    issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy", bus.busy, 1);
    wait_done(e);
    check("mult_edges", e, 33);
    check("mult_hi",    bus.hi, 32'hFFFF_FFFF);
    check("mult_lo",    bus.lo, 32'hFFFF_FFEB);
    check("mult_busy_done", bus.busy, 0);

    // Back-to-back: MULTU accepted in the done cycle
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy", bus.busy, 1);
    wait_done(e);
    check("multu_edges", e, 33);
    check("multu_hi",    bus.hi, 32'hFFFF_FFFE);
    check("multu_lo",    bus.lo, 32'h0000_0001);

`ifdef MULDIV_DIV_EN
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(e);
    check("div_edges", e, 33);
    check("div_lo",    bus.lo, 32'hFFFF_FFFD);
    check("div_hi",    bus.hi, 32'hFFFF_FFFF);

    issue(FUNCT_DIVU, 32'd100, 32'd0);
    wait_done(e);
    check("dbz_edges", e, 1);
    check("dbz_hi",    bus.hi, 32'd100);
    check("dbz_lo",    bus.lo, 32'hFFFF_FFFF);
    check("dbz_flag",  bus.div_by_zero, 1);

    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("dbz_clear", bus.div_by_zero, 0);
    wait_done(e);
    check("ovf_lo",   bus.lo, 32'h8000_0000);
    check("ovf_hi",   bus.hi, 32'h0);
    check("ovf_flag", bus.div_by_zero, 0);
`else
    issue(FUNCT_DIV, 32'd100, 32'd0);
    check("nodiv_busy", bus.busy, 0);
    check("nodiv_hi",   bus.hi, 32'hFFFF_FFFE);
    check("nodiv_lo",   bus.lo, 32'h0000_0001);
    check("nodiv_dbz",  bus.div_by_zero, 0);
    issue(FUNCT_MULT, 32'd2, 32'd2);
    bus.start = 1'b1;
    bus.funct = FUNCT_DIVU;
    #1;
    check("nodiv_stall", bus.stall, 0);
    bus.start = 1'b0;
    wait_done(e);
    check("nodiv_mult_lo", bus.lo, 32'd4);
`endif

    // MFLO held during busy: stalls until the done cycle
    issue(FUNCT_MULT, 32'd3, 32'd5);
    bus.start = 1'b1;
    bus.funct = FUNCT_MFLO;
    stalls = 0;
    e = 0;
    #1;
    while (!bus.done && e < 60) begin
      if (bus.stall) stalls++;
      @(posedge clk);
      e++;
      #1;
    end
    check("mflo_stall_cycles", stalls, 33);
    check("mflo_release",      bus.stall, 0);
    check("mflo_lo",           bus.lo, 32'd15);
    check("mflo_hi",           bus.hi, 32'd0);
    bus.start = 1'b0;

    // flush at cycle 10 of a MULT
    issue(FUNCT_MTHI, 32'h0000_AAAA, 32'h0);
    issue(FUNCT_MTLO, 32'h0000_BBBB, 32'h0);
    issue(FUNCT_MULT, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_hi",   bus.hi, 32'h0000_AAAA);
    check("flush_lo",   bus.lo, 32'h0000_BBBB);
    watch_no_done(40, seen);
    check("flush_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
